// File: rtl/time_setup_editor_if.sv
// Button levels in, edited time / field code / blink mask / commit pulse out.
interface time_setup_editor_if;
    logic        enter;
    logic        inc;
    logic        dec;
    logic        cancel;
    logic [23:0] current_data;
    logic [23:0] setup_data;
    logic [1:0]  setup_rezhim;
    logic        commit;
    logic [2:0]  blink;

    modport master (output enter, inc, dec, cancel, current_data,
                    input  setup_data, setup_rezhim, commit, blink);
    modport slave  (input  enter, inc, dec, cancel, current_data,
                    output setup_data, setup_rezhim, commit, blink);
endinterface

// File: rtl/time_setup_editor.sv
// Time setup editor: loads the running time, steps hour/min/sec with wrap and
// auto-repeat, drives a blink mask for the active field and pulses commit.
module time_setup_editor #(
    parameter int HOLD_CYCLES   = 25000000,
    parameter int REPEAT_CYCLES = 5000000,
    parameter int BLINK_CYCLES  = 12500000
) (
    input  logic               clock,
    input  logic               reset,
    time_setup_editor_if.slave bus
);
    localparam int RPT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int RW      = $clog2(RPT_MAX + 1);
    localparam int BW      = $clog2(BLINK_CYCLES + 1);

    localparam logic [RW-1:0] HOLD_C     = RW'(HOLD_CYCLES);
    localparam logic [RW-1:0] REPEAT_C   = RW'(REPEAT_CYCLES);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);
    localparam logic [7:0]    HOUR_MAX   = 8'd23;
    localparam logic [7:0]    MINSEC_MAX = 8'd59;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOUR = 2'd1,
        S_MIN  = 2'd2,
        S_SEC  = 2'd3
    } state_t;

    state_t        state_r, state_n_s;
    logic          enter_q_r, inc_q_r, dec_q_r, cancel_q_r;
    logic [23:0]   data_r, data_n_s;
    logic [1:0]    rezhim_r;
    logic          commit_r, commit_n_s;
    logic [2:0]    blink_r, blink_n_s;
    logic [RW-1:0] rcnt_r, rcnt_n_s;
    logic          rphase_r, rphase_n_s;
    logic [BW-1:0] bcnt_r, bcnt_n_s;
    logic          bphase_r, bphase_n_s;
    logic          enter_e_s, inc_e_s, dec_e_s, cancel_e_s;
    logic          one_s, rpt_hit_s, step_s;
    logic [7:0]    field_s, field_max_s, field_n_s;

    function automatic logic [7:0] wrap_step(input logic [7:0] v, input logic [7:0] vmax,
                                             input logic up);
        logic [7:0] r;
        if (up) begin
            r = (v >= vmax) ? 8'd0 : v + 8'd1;
        end else begin
            r = ((v == 8'd0) || (v > vmax)) ? vmax : v - 8'd1;
        end
        return r;
    endfunction

    function automatic logic [7:0] clamp(input logic [7:0] v, input logic [7:0] vmax);
        return (v > vmax) ? 8'd0 : v;
    endfunction

    assign enter_e_s  = bus.enter  & ~enter_q_r;
    assign inc_e_s    = bus.inc    & ~inc_q_r;
    assign dec_e_s    = bus.dec    & ~dec_q_r;
    assign cancel_e_s = bus.cancel & ~cancel_q_r;
    assign one_s      = bus.inc ^ bus.dec;
    // A zero count means no edge has armed the repeat timer yet.
    assign rpt_hit_s  = (rcnt_r != {RW{1'b0}}) && (rcnt_r == (rphase_r ? REPEAT_C : HOLD_C));
    assign field_n_s  = wrap_step(field_s, field_max_s, bus.inc);

    // Select the field under edit and its wrap limit.
    always_comb begin
        field_s     = 8'd0;
        field_max_s = MINSEC_MAX;
        case (state_r)
            S_HOUR: begin
                field_s     = data_r[23:16];
                field_max_s = HOUR_MAX;
            end
            S_MIN:   field_s = data_r[15:8];
            S_SEC:   field_s = data_r[7:0];
            default: field_s = 8'd0;
        endcase
    end

    // Next state, edited value, commit and adjust step.
    always_comb begin
        state_n_s  = state_r;
        data_n_s   = data_r;
        commit_n_s = 1'b0;
        step_s     = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (enter_e_s) begin
                    state_n_s = S_HOUR;
                    data_n_s  = {clamp(bus.current_data[23:16], HOUR_MAX),
                                 clamp(bus.current_data[15:8],  MINSEC_MAX),
                                 clamp(bus.current_data[7:0],   MINSEC_MAX)};
                end else begin
                    state_n_s = S_IDLE;
                end
            end
            default: begin
                if (cancel_e_s) begin
                    state_n_s = S_IDLE;
                end else if (enter_e_s) begin
                    case (state_r)
                        S_HOUR:  state_n_s = S_MIN;
                        S_MIN:   state_n_s = S_SEC;
                        default: begin
                            state_n_s  = S_IDLE;
                            commit_n_s = 1'b1;
                        end
                    endcase
                end else if (one_s && (inc_e_s || dec_e_s || rpt_hit_s)) begin
                    step_s = 1'b1;
                    case (state_r)
                        S_HOUR:  data_n_s[23:16] = field_n_s;
                        S_MIN:   data_n_s[15:8]  = field_n_s;
                        default: data_n_s[7:0]   = field_n_s;
                    endcase
                end else begin
                    step_s = 1'b0;
                end
            end
        endcase
    end

    // Auto-repeat timer: armed by an inc/dec edge, HOLD first, then REPEAT.
    always_comb begin
        rcnt_n_s   = rcnt_r;
        rphase_n_s = rphase_r;
        if ((state_r == S_IDLE) || (state_n_s != state_r) || !one_s) begin
            rcnt_n_s   = {RW{1'b0}};
            rphase_n_s = 1'b0;
        end else if (inc_e_s || dec_e_s) begin
            rcnt_n_s   = {{(RW-1){1'b0}}, 1'b1};
            rphase_n_s = 1'b0;
        end else if (rcnt_r == {RW{1'b0}}) begin
            rcnt_n_s   = {RW{1'b0}};
        end else if (rpt_hit_s) begin
            rcnt_n_s   = {{(RW-1){1'b0}}, 1'b1};
            rphase_n_s = 1'b1;
        end else begin
            rcnt_n_s   = rcnt_r + {{(RW-1){1'b0}}, 1'b1};
        end
    end

    // Blink phase and mask for the field that will be active next cycle.
    always_comb begin
        bcnt_n_s   = bcnt_r;
        bphase_n_s = bphase_r;
        blink_n_s  = 3'b000;
        if ((state_n_s == S_IDLE) || (state_n_s != state_r) || step_s) begin
            bcnt_n_s   = {BW{1'b0}};
            bphase_n_s = 1'b0;
        end else if (bcnt_r == BLINK_LAST) begin
            bcnt_n_s   = {BW{1'b0}};
            bphase_n_s = ~bphase_r;
        end else begin
            bcnt_n_s   = bcnt_r + {{(BW-1){1'b0}}, 1'b1};
        end
        case (state_n_s)
            S_HOUR:  blink_n_s = {bphase_n_s, 2'b00};
            S_MIN:   blink_n_s = {1'b0, bphase_n_s, 1'b0};
            S_SEC:   blink_n_s = {2'b00, bphase_n_s};
            default: blink_n_s = 3'b000;
        endcase
    end

    // State, counters, button history and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= S_IDLE;
            enter_q_r  <= 1'b0;
            inc_q_r    <= 1'b0;
            dec_q_r    <= 1'b0;
            cancel_q_r <= 1'b0;
            data_r     <= 24'd0;
            rezhim_r   <= 2'd0;
            commit_r   <= 1'b0;
            blink_r    <= 3'b000;
            rcnt_r     <= {RW{1'b0}};
            rphase_r   <= 1'b0;
            bcnt_r     <= {BW{1'b0}};
            bphase_r   <= 1'b0;
        end else begin
            state_r    <= state_n_s;
            enter_q_r  <= bus.enter;
            inc_q_r    <= bus.inc;
            dec_q_r    <= bus.dec;
            cancel_q_r <= bus.cancel;
            data_r     <= data_n_s;
            rezhim_r   <= state_n_s;
            commit_r   <= commit_n_s;
            blink_r    <= blink_n_s;
            rcnt_r     <= rcnt_n_s;
            rphase_r   <= rphase_n_s;
            bcnt_r     <= bcnt_n_s;
            bphase_r   <= bphase_n_s;
        end
    end

    assign bus.setup_data   = data_r;
    assign bus.setup_rezhim = rezhim_r;
    assign bus.commit       = commit_r;
    assign bus.blink        = blink_r;
endmodule

// File: tb/tb_time_setup_editor.sv
// Bench for time_setup_editor: directed scenarios plus random button traffic,
// checked every cycle against a field/timer-level model of the editor.
module tb_time_setup_editor;
    localparam int HOLD = 4;
    localparam int REP  = 2;
    localparam int BLK  = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    time_setup_editor_if bus();

    time_setup_editor #(.HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .BLINK_CYCLES(BLK)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;
    int cyc = 0;

    // Model: mode 0 idle, 1..3 = hour/min/sec; t = cycles since blink restart;
    // k = cycles since the armed inc/dec edge.
    int m_mode = 0;
    int m_f[3] = '{0, 0, 0};
    int fmax[3] = '{23, 59, 59};
    bit m_commit = 1'b0;
    int m_blink = 0;
    bit m_armed = 1'b0;
    int m_k = 0;
    int m_t = 0;
    bit m_prev[4] = '{1'b0, 1'b0, 1'b0, 1'b0};

    task automatic model_step(input bit e, input bit i, input bit d, input bit c);
        bit ee, ie, de, ce, one, step;
        int old, j;
        if (reset) begin
            m_mode = 0; m_f = '{0, 0, 0}; m_commit = 1'b0; m_armed = 1'b0;
            m_k = 0; m_t = 0; m_blink = 0; m_prev = '{1'b0, 1'b0, 1'b0, 1'b0};
            return;
        end
        ee = e && !m_prev[0];
        ie = i && !m_prev[1];
        de = d && !m_prev[2];
        ce = c && !m_prev[3];
        one = (i != d);
        old = m_mode;
        step = 1'b0;
        m_commit = 1'b0;
        if (m_mode == 0) begin
            if (ee) begin
                m_f[0] = int'(bus.current_data[23:16]);
                m_f[1] = int'(bus.current_data[15:8]);
                m_f[2] = int'(bus.current_data[7:0]);
                for (int q = 0; q < 3; q++) if (m_f[q] > fmax[q]) m_f[q] = 0;
                m_mode = 1;
            end
        end else if (ce) begin
            m_mode = 0;
        end else if (ee) begin
            if (m_mode == 3) begin m_mode = 0; m_commit = 1'b1; end
            else m_mode = m_mode + 1;
        end else if (one) begin
            if (ie || de) begin
                step = 1'b1; m_armed = 1'b1; m_k = 0;
            end else if (m_armed) begin
                m_k = m_k + 1;
                step = (m_k == HOLD) || (m_k > HOLD && ((m_k - HOLD) % REP) == 0);
            end
            if (step) begin
                j = m_mode - 1;
                if (i) m_f[j] = (m_f[j] == fmax[j]) ? 0 : m_f[j] + 1;
                else   m_f[j] = (m_f[j] == 0) ? fmax[j] : m_f[j] - 1;
            end
        end
        if (m_mode == 0 || m_mode != old || !one) m_armed = 1'b0;
        if (m_mode == 0 || m_mode != old || step) m_t = 0;
        else m_t = m_t + 1;
        m_blink = (m_mode == 0) ? 0 : (((m_t / BLK) % 2) << (3 - m_mode));
        m_prev = '{e, i, d, c};
    endtask

    task automatic tick(input bit e, input bit i, input bit d, input bit c);
        bus.enter = e; bus.inc = i; bus.dec = d; bus.cancel = c;
        @(posedge clock);
        model_step(e, i, d, c);
        @(negedge clock);
    endtask

    task automatic press(input bit e, input bit i, input bit d, input bit c);
        tick(e, i, d, c);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clock) begin
        cyc++;
        if (chk_en) begin
            n_cmp++;
            if ({bus.setup_data, bus.setup_rezhim, bus.commit, bus.blink} !==
                {8'(m_f[0]), 8'(m_f[1]), 8'(m_f[2]), 2'(m_mode), m_commit, 3'(m_blink)}) begin
                n_bad++;
                $display("FAIL model cyc %0d: got data=%h rezhim=%0d commit=%b blink=%b, expected data=%02h%02h%02h rezhim=%0d commit=%b blink=%03b",
                         cyc, bus.setup_data, bus.setup_rezhim, bus.commit, bus.blink,
                         8'(m_f[0]), 8'(m_f[1]), 8'(m_f[2]), m_mode, m_commit, 3'(m_blink));
            end
        end
    end

    initial begin
        bit lv[4];
        bus.enter = 1'b0; bus.inc = 1'b0; bus.dec = 1'b0; bus.cancel = 1'b0;
        bus.current_data = 24'h000000;
        reset = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        chk_en = 1'b1;
        chk("reset_outputs", {2'b00, bus.setup_data, bus.setup_rezhim, bus.commit, bus.blink}, 32'h0);
        reset = 1'b0;

        // Load with out-of-range hour and second.
        bus.current_data = 24'h1E3B40;
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        chk("load_rezhim", {30'd0, bus.setup_rezhim}, 32'd1);
        chk("load_clamp", {8'd0, bus.setup_data}, 32'h003B00);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b0, 1'b1);
        chk("cancel_idle", {30'd0, bus.setup_rezhim}, 32'd0);

        // Full edit from 23:59:59.
        bus.current_data = 24'h173B3B;
        press(1'b1, 1'b0, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0, 1'b0);
        chk("hour_wrap_up", {8'd0, bus.setup_data}, 32'h003B3B);
        press(1'b1, 1'b0, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1, 1'b0);
        chk("min_dec", {8'd0, bus.setup_data}, 32'h003A3B);
        press(1'b1, 1'b0, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0, 1'b0);
        chk("sec_wrap_up", {8'd0, bus.setup_data}, 32'h003A00);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        chk("commit_pulse", {29'd0, bus.commit, bus.setup_rezhim}, {29'd0, 1'b1, 2'd0});
        chk("commit_data", {8'd0, bus.setup_data}, 32'h003A00);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        chk("commit_one_cycle", {31'd0, bus.commit}, 32'd0);

        // Auto-repeat in MIN starting from 10.
        bus.current_data = 24'h000A00;
        press(1'b1, 1'b0, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 10; n++) tick(1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        chk("auto_repeat", {8'd0, bus.setup_data}, 32'h000E00);
        for (int n = 0; n < 8; n++) tick(1'b0, 1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        chk("both_held", {8'd0, bus.setup_data}, 32'h000E00);

        // Cancel and enter together in SEC.
        press(1'b1, 1'b0, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        chk("cancel_prio", {5'd0, bus.commit, bus.setup_rezhim, bus.setup_data},
            {5'd0, 1'b0, 2'd0, 24'h000E01});
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        chk("cancel_no_commit", {31'd0, bus.commit}, 32'd0);

        // Blink in HOUR, restart on inc, then MIN.
        bus.current_data = 24'h010203;
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        chk("blink_c1", {29'd0, bus.blink}, 32'd0);
        for (int n = 2; n <= 7; n++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b0);
            chk("blink_hour", {29'd0, bus.blink}, (((n - 1) / 3) % 2 == 1) ? 32'd4 : 32'd0);
        end
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        chk("blink_inc_restart", {29'd0, bus.blink}, 32'd0);
        for (int n = 1; n <= 3; n++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b0);
            chk("blink_after_inc", {29'd0, bus.blink}, (n == 3) ? 32'd4 : 32'd0);
        end
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        chk("blink_min_enter", {29'd0, bus.blink}, 32'd0);
        for (int n = 1; n <= 3; n++) tick(1'b0, 1'b0, 1'b0, 1'b0);
        chk("blink_min", {29'd0, bus.blink}, 32'd2);

        // Reset in MIN with 05:06:07.
        press(1'b0, 1'b0, 1'b0, 1'b1);
        bus.current_data = 24'h050607;
        press(1'b1, 1'b0, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0, 1'b0);
        chk("pre_reset", {6'd0, bus.setup_rezhim, bus.setup_data}, {6'd0, 2'd2, 24'h050607});
        reset = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset_mid_edit", {2'b00, bus.setup_data, bus.setup_rezhim, bus.commit, bus.blink}, 32'h0);
        reset = 1'b0;
        tick(1'b0, 1'b0, 1'b0, 1'b0);

        // Random button traffic.
        lv = '{1'b0, 1'b0, 1'b0, 1'b0};
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 9) == 0)  lv[0] = !lv[0];
            if ($urandom_range(0, 5) == 0)  lv[1] = !lv[1];
            if ($urandom_range(0, 5) == 0)  lv[2] = !lv[2];
            if ($urandom_range(0, 29) == 0) lv[3] = !lv[3];
            reset = ($urandom_range(0, 399) == 0);
            bus.current_data = {8'($urandom_range(0, 30)), 8'($urandom_range(0, 66)),
                                8'($urandom_range(0, 66))};
            tick(lv[0], lv[1], lv[2], lv[3]);
        end
        reset = 1'b0;
        tick(1'b0, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/time_setup_editor.md
Name: time_setup_editor

Overview:
- Front-end editor for setting the clock time from four debounced buttons.
- Loads the running time, then lets the user step through the hour, minute and second fields, adjusting each with wrap-around and auto-repeat.
- Outputs the packed edited value, the active field code for the display mux, a per-field blink mask, and a one-cycle commit pulse that loads the time counter.

Parameters:
- HOLD_CYCLES, 25000000, cycles an inc/dec button must be held before auto-repeat starts.
- REPEAT_CYCLES, 5000000, cycles between auto-repeat steps while the button stays held.
- BLINK_CYCLES, 12500000, cycles per blink phase (half period).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- enter  in  1  debounced level; a rising edge starts the edit or advances to the next field
- inc  in  1  debounced level; increment the active field
- dec  in  1  debounced level; decrement the active field
- cancel  in  1  debounced level; a rising edge aborts the edit without commit
- current_data  in  24  running time {hour[23:16], min[15:8], sec[7:0]}, binary
- setup_data  out  24  edited time, same packing
- setup_rezhim  out  2  0 = idle, 1 = hour, 2 = min, 3 = sec
- commit  out  1  one-cycle pulse; setup_data is valid to load in that cycle
- blink  out  3  blank mask {hour, min, sec}; 1 = blank that digit pair

Behaviour:
- Reset, on any clock edge with reset=1, including mid-edit:
  - setup_data=0, setup_rezhim=0, commit=0, blink=0.
  - Edge registers, repeat counter and blink counter cleared.
- Edge detection:
  - Each button is registered once; edge = level & ~level_q.
  - A state update happens on the clock edge where the edge is visible, so outputs change one cycle after the detected edge.
- FSM states are IDLE, HOUR, MIN, SEC.
- IDLE:
  - enter edge loads setup_data from current_data and moves to HOUR.
  - Any loaded field out of range (hour>23, min>59, sec>59) is forced to 0.
  - inc, dec and cancel are ignored.
- HOUR -> MIN -> SEC on each enter edge.
- SEC + enter edge -> IDLE:
  - commit=1 for exactly the cycle in which setup_rezhim first reads 0.
  - setup_data holds its value.
- Any edit state + cancel edge -> IDLE, commit stays 0, setup_data holds.
- Priority when edges coincide: cancel > enter > inc/dec. Inc/dec are not applied in a cycle where a state transition occurs.
- Adjust:
  - An inc edge adds 1 to the active field; a dec edge subtracts 1.
  - Wrap: hour 23->0 and 0->23; min/sec 59->0 and 0->59.
  - Other fields are never modified.
- Auto-repeat:
  - While exactly one of inc/dec is held, the repeat counter counts from its edge.
  - First extra step at HOLD_CYCLES after the edge step, then one step every REPEAT_CYCLES.
  - Release, inc and dec both high, or a field change resets the counter.
  - Both high: no adjust at all.
- Blink:
  - A free-running counter toggles a phase bit every BLINK_CYCLES while not IDLE.
  - The blink bit of the active field = phase; the other bits = 0.
  - Phase is forced to 0 (visible) and the counter is cleared on any field change or adjust step.
  - blink=0 in IDLE.
- Width and arithmetic: fields are 8-bit binary, compared and wrapped in 8-bit arithmetic, never BCD.

Test Plan (HOLD_CYCLES=4, REPEAT_CYCLES=2, BLINK_CYCLES=3):
- Load clamp: current_data=0x1E_3B_40 (30,59,64), enter pulse -> setup_rezhim=1 one cycle after the edge, setup_data=0x00_3B_00.
- Full edit:
  - Load 23:59:59.
  - inc in HOUR -> hour 0.
  - enter, then dec in MIN -> min 58.
  - enter, then inc in SEC -> sec 0.
  - enter -> commit=1 for one cycle with setup_rezhim=0, setup_data=0x00_3A_00.
- Auto-repeat:
  - In MIN with min=10, hold inc 10 cycles from the edge.
  - Required steps at edge+0, +4, +6, +8 -> min=14.
  - Hold inc and dec together -> min unchanged.
- Cancel:
  - In SEC after edits, cancel and enter edges in the same cycle.
  - Result: IDLE, commit never asserts, setup_data unchanged.
- Blink:
  - In HOUR with no buttons, blink toggles 3'b000/3'b100 every 3 cycles.
  - An inc edge forces blink=000 and restarts the phase.
  - After enter to MIN, only bit 1 toggles.
- Reset mid-edit: assert reset in MIN with setup_data=0x05_06_07 -> next cycle all outputs 0, state IDLE.
